// File: rtl/flash_cache_pkg.sv
// rtl/flash_cache_pkg.sv - shared types and address-split width helpers for flash_cache
package flash_cache_pkg;

    localparam int ADDR_W = 24;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_FILL,
        ST_RESPOND
    } state_t;

    function automatic int word_bits(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

    function automatic int index_bits(input int lines);
        return $clog2(lines);
    endfunction

    // Byte offset [1:0] is dropped; the tag takes whatever is left above word and index.
    function automatic int tag_bits(input int lines, input int words_per_line);
        return ADDR_W - 2 - word_bits(words_per_line) - index_bits(lines);
    endfunction

endpackage

// File: rtl/flash_cache_data_ram.sv
// rtl/flash_cache_data_ram.sv - single-port synchronous line-data store for flash_cache
module flash_cache_data_ram
    import flash_cache_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic              clk_cpu,
    input  logic              en,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_cpu) begin
        if (en) begin
            if (we) begin
                mem_q[addr] <= wdata;
            end else begin
                rdata_q <= mem_q[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/flash_cache.sv
// rtl/flash_cache.sv - direct-mapped read cache in front of a flash burst reader; FLASH_CACHE_STATS_EN builds hit/miss counters
module flash_cache
    import flash_cache_pkg::*;
#(
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic              clk_cpu,
    input  logic              n_reset,
    input  logic              cpu_valid,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [3:0]        cpu_wstrb,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              flush,
    output logic              sfr_start,
    output logic [ADDR_W-1:0] sfr_address,
    output logic [ADDR_W-1:0] sfr_word_count,
    input  logic              sfr_strobe,
    input  logic [DATA_W-1:0] sfr_data,
    input  logic              sfr_done,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
);

    localparam int WB  = word_bits(WORDS_PER_LINE);
    localparam int IB  = index_bits(LINES);
    localparam int TW  = tag_bits(LINES, WORDS_PER_LINE);
    localparam int RAW = WB + IB;
    localparam int CW  = WB + 1;
    localparam logic [21:0] WORD_MASK = 22'(WORDS_PER_LINE - 1);

    state_t              state_q, state_d;
    logic [21:0]         req_addr_q, req_addr_d;
    logic                req_write_q, req_write_d;
    logic [CW-1:0]       fill_cnt_q, fill_cnt_d;
    logic [DATA_W-1:0]   crit_q, crit_d;
    logic                flushed_q, flushed_d;
    logic [LINES-1:0]    valid_q, valid_d;
    logic [TW-1:0]       tag_q [LINES];
    logic [TW-1:0]       tag_d [LINES];
    logic                cpu_ready_q, cpu_ready_d;
    logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic                sfr_start_q, sfr_start_d;
    logic [ADDR_W-1:0]   sfr_address_q, sfr_address_d;

    logic                ram_en, ram_we;
    logic [RAW-1:0]      ram_addr;
    logic [DATA_W-1:0]   ram_rdata;

    logic [IB-1:0]       req_index;
    logic [TW-1:0]       req_tag;
    logic [CW-1:0]       req_word;
    logic                lookup_hit;
    logic [1:0]          unused_byte_offset;

    assign req_index          = IB'(req_addr_q >> WB);
    assign req_tag            = TW'(req_addr_q >> (WB + IB));
    assign req_word           = CW'(req_addr_q & WORD_MASK);
    assign unused_byte_offset = cpu_addr[1:0];

    // A flush landing on the lookup cycle must not let a stale line hit.
    assign lookup_hit = valid_q[req_index] && (tag_q[req_index] == req_tag) && !flush;

    flash_cache_data_ram #(
        .DEPTH (LINES * WORDS_PER_LINE),
        .AW    (RAW)
    ) u_data_ram (
        .clk_cpu (clk_cpu),
        .en      (ram_en),
        .we      (ram_we),
        .addr    (ram_addr),
        .wdata   (sfr_data),
        .rdata   (ram_rdata)
    );

    always_comb begin
        state_d       = state_q;
        req_addr_d    = req_addr_q;
        req_write_d   = req_write_q;
        fill_cnt_d    = fill_cnt_q;
        crit_d        = crit_q;
        flushed_d     = flushed_q;
        valid_d       = valid_q;
        tag_d         = tag_q;
        cpu_ready_d   = 1'b0;
        cpu_rdata_d   = '0;
        sfr_start_d   = 1'b0;
        sfr_address_d = sfr_address_q;
        ram_en        = 1'b0;
        ram_we        = 1'b0;
        ram_addr      = RAW'(cpu_addr[23:2]);

        if (flush) begin
            valid_d = '0;
        end

        case (state_q)
            ST_IDLE: begin
                // Read the data RAM now so the word is ready when the tag compare resolves.
                if (cpu_valid && !cpu_ready_q) begin
                    state_d     = ST_LOOKUP;
                    req_addr_d  = cpu_addr[23:2];
                    req_write_d = |cpu_wstrb;
                    ram_en      = 1'b1;
                end
            end
            ST_LOOKUP: begin
                if (req_write_q) begin
                    cpu_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end else if (lookup_hit) begin
                    cpu_ready_d = 1'b1;
                    cpu_rdata_d = ram_rdata;
                    state_d     = ST_IDLE;
                end else begin
                    sfr_start_d   = 1'b1;
                    sfr_address_d = {req_addr_q & ~WORD_MASK, 2'b00};
                    fill_cnt_d    = '0;
                    flushed_d     = 1'b0;
                    state_d       = ST_FILL;
                end
            end
            ST_FILL: begin
                if (flush) begin
                    flushed_d = 1'b1;
                end
                // The counter stops at WORDS_PER_LINE so surplus strobes cannot spill into the next line.
                if (sfr_strobe && (fill_cnt_q < CW'(WORDS_PER_LINE))) begin
                    ram_en     = 1'b1;
                    ram_we     = 1'b1;
                    ram_addr   = RAW'(req_addr_q & ~WORD_MASK) | RAW'(fill_cnt_q);
                    fill_cnt_d = fill_cnt_q + CW'(1);
                    if (fill_cnt_q == req_word) begin
                        crit_d = sfr_data;
                    end
                end
                if (sfr_done) begin
                    tag_d[req_index] = req_tag;
                    if (!(flush || flushed_q)) begin
                        valid_d[req_index] = 1'b1;
                    end
                    state_d = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                cpu_ready_d = 1'b1;
                cpu_rdata_d = crit_q;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_cpu or negedge n_reset) begin
        if (!n_reset) begin
            state_q       <= ST_IDLE;
            req_addr_q    <= '0;
            req_write_q   <= 1'b0;
            fill_cnt_q    <= '0;
            crit_q        <= '0;
            flushed_q     <= 1'b0;
            valid_q       <= '0;
            tag_q         <= '{default: '0};
            cpu_ready_q   <= 1'b0;
            cpu_rdata_q   <= '0;
            sfr_start_q   <= 1'b0;
            sfr_address_q <= '0;
        end else begin
            state_q       <= state_d;
            req_addr_q    <= req_addr_d;
            req_write_q   <= req_write_d;
            fill_cnt_q    <= fill_cnt_d;
            crit_q        <= crit_d;
            flushed_q     <= flushed_d;
            valid_q       <= valid_d;
            tag_q         <= tag_d;
            cpu_ready_q   <= cpu_ready_d;
            cpu_rdata_q   <= cpu_rdata_d;
            sfr_start_q   <= sfr_start_d;
            sfr_address_q <= sfr_address_d;
        end
    end

    assign cpu_ready      = cpu_ready_q;
    assign cpu_rdata      = cpu_rdata_q;
    assign sfr_start      = sfr_start_q;
    assign sfr_address    = sfr_address_q;
    assign sfr_word_count = ADDR_W'(WORDS_PER_LINE);

`ifdef FLASH_CACHE_STATS_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;

    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (state_q == ST_LOOKUP && !req_write_q) begin
            if (lookup_hit) begin
                hit_count_d = hit_count_q + 32'd1;
            end else begin
                miss_count_d = miss_count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_cpu or negedge n_reset) begin
        if (!n_reset) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: doc/flash_cache.md
FLASH_CACHE -- requirements
Module: flash_cache

Interface
REQ-001 Parameter LINES, default 16, number of direct-mapped lines (power of two, 2..64).
REQ-002 Parameter WORDS_PER_LINE, default 4, 32-bit words per line (power of two, 1..16).
REQ-003 clk_cpu  input  1  system clock; all logic on rising edge.
REQ-004 n_reset  input  1  asynchronous, active-low reset.
REQ-005 cpu_valid  input  1  CPU request, held until cpu_ready.
REQ-006 cpu_addr  input  24  byte address within flash window.
REQ-007 cpu_wstrb  input  4  nonzero = write request.
REQ-008 cpu_ready  output  1  one-cycle completion pulse.
REQ-009 cpu_rdata  output  32  read data, valid while cpu_ready=1.
REQ-010 flush  input  1  single-cycle pulse; invalidates all lines.
REQ-011 sfr_start  output  1  single-cycle pulse starting a flash line read.
REQ-012 sfr_address  output  24  line-aligned byte address for the burst.
REQ-013 sfr_word_count  output  24  constant WORDS_PER_LINE.
REQ-014 sfr_strobe  input  1  one returned word valid on sfr_data.
REQ-015 sfr_data  input  32  returned flash word.
REQ-016 sfr_done  input  1  burst complete pulse.
REQ-017 hit_count  output  32  read-hit counter.
REQ-018 miss_count  output  32  read-miss counter.

Function
REQ-019 Address split SHALL be: offset [1:0] ignored, word = next log2(WORDS_PER_LINE) bits, index = next log2(LINES) bits, tag = remaining upper bits.
REQ-020 FSM states SHALL be IDLE, LOOKUP, FILL, RESPOND.
REQ-021 IDLE -> LOOKUP when cpu_valid=1 and cpu_ready=0; LOOKUP registers tag/valid read.
REQ-022 Read hit in LOOKUP: cpu_ready=1 with cached word next cycle (2 cycles after cpu_valid), return IDLE.
REQ-023 Read miss in LOOKUP: pulse sfr_start one cycle with sfr_address = {tag,index,0}, enter FILL.
REQ-024 In FILL each sfr_strobe SHALL write sfr_data into data RAM at an internal fill counter (0..WORDS_PER_LINE-1), then increment it.
REQ-025 Word whose fill counter equals request word SHALL be captured into a critical-word register.
REQ-026 sfr_done in FILL: write tag, set valid bit, enter RESPOND; RESPOND asserts cpu_ready one cycle with critical word, then IDLE.
REQ-027 Strobes beyond WORDS_PER_LINE in one burst SHALL be ignored (counter saturates).
REQ-028 Write requests (cpu_wstrb!=0) SHALL be acked one cycle after LOOKUP with no cache or flash effect; cpu_rdata=0.
REQ-029 cpu_ready SHALL never be high two consecutive cycles; cpu_rdata=0 when cpu_ready=0.
REQ-030 flush in IDLE/LOOKUP/RESPOND: clear all valid bits next cycle; a LOOKUP coinciding with flush SHALL be treated as miss.
REQ-031 flush during FILL: clear valid bits, burst continues, line NOT marked valid at sfr_done, CPU still served critical word.
REQ-032 sfr_strobe/sfr_done outside FILL SHALL be ignored.
REQ-033 hit_count/miss_count SHALL increment on each read hit/miss decision, wrap at 2^32.

Reset
REQ-034 n_reset low SHALL asynchronously force IDLE, all valid bits 0, fill counter 0, counters 0, cpu_ready=0, cpu_rdata=0, sfr_start=0, sfr_address=0.
REQ-035 Reset mid-FILL SHALL abandon the burst; no line marked valid after release. Data RAM contents need not reset.

Configuration
REQ-036 Macro FLASH_CACHE_STATS_EN defined: hit_count/miss_count per REQ-033.
REQ-037 Macro undefined: counters not built, hit_count and miss_count tied to 0; ports remain.

Structure
REQ-038 Package flash_cache_pkg SHALL hold FSM state enum and width-calculation functions for word/index/tag.
REQ-039 Data storage SHALL be sub-module flash_cache_data_ram (single-port synchronous, LINES*WORDS_PER_LINE x 32, one read or write per cycle); tags/valid bits in registers in flash_cache.

Verification
REQ-040 Cold read 0x000104 -> sfr_start once, sfr_address=0x000100, word_count=4, four strobes 0xA0..0xA3 -> cpu_rdata=0xA1, miss_count=1.
REQ-041 Repeat read 0x00010C -> no sfr_start, cpu_ready 2 cycles after cpu_valid, cpu_rdata=0xA3, hit_count=1.
REQ-042 Read 0x001104 (same index, new tag) -> refill, line replaced; subsequent 0x000104 read misses again.
REQ-043 flush pulse during FILL of 0x000200 -> CPU gets correct word; next read 0x000200 misses.
REQ-044 Write 0xDEADBEEF, wstrb=0xF, to 0x000100 -> cpu_ready pulse, no sfr_start, next read of 0x000100 returns prior data.
REQ-045 n_reset asserted after second strobe of a fill -> outputs at reset values; after release read same address misses (stats counters 0 with FLASH_CACHE_STATS_EN).
